// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Purpose  : Exception/interrupt arbiter. Selects the highest-priority
//            pipeline exception (MEM > ID > IF > interrupt), issues it to cp0
//            for one cycle, then flushes/stalls until cp0 acknowledges.
//            Optional macro EXC_CTRL_TIMER_INT_EN ORs int_timer_req into IP7.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] status,
    input  logic [5:0]  hw_int,
    input  logic        int_timer_req,
    output logic [7:0]  cause_ip,
    input  logic        if_adel,
    input  logic [31:0] if_pc,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_bd,
    input  logic        id_sys,
    input  logic        id_ri,
    input  logic        id_eret,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [31:0] mem_addr,
    input  logic [2:0]  mem_exc,
    input  logic        mem_we,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    input  logic        exc_jmp_flag,
    output logic        flush,
    output logic        stall
);

    localparam logic [4:0] C_EC_INT  = 5'd0;
    localparam logic [4:0] C_EC_TLBL = 5'd2;
    localparam logic [4:0] C_EC_TLBS = 5'd3;
    localparam logic [4:0] C_EC_ADEL = 5'd4;
    localparam logic [4:0] C_EC_ADES = 5'd5;
    localparam logic [4:0] C_EC_SYS  = 5'd8;
    localparam logic [4:0] C_EC_RI   = 5'd10;
    localparam logic [4:0] C_EC_ERET = 5'd30;
    localparam logic [4:0] C_EC_NONE = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_sync1;
    logic [5:0]  r_sync2;
    logic [4:0]  r_code;
    logic [31:0] r_epc;
    logic [31:0] r_bad;
    logic        r_busy;

    logic        w_ip7;
    logic        w_mem_req;
    logic        w_id_req;
    logic        w_int_req;
    logic [31:0] w_mem_epc;
    logic [31:0] w_id_epc;
    logic        w_req;
    logic [4:0]  w_code;
    logic [31:0] w_epc;
    logic [31:0] w_bad;
    logic        w_unused;

    // Timer request bypasses the synchronizer: it originates in the cp0 clock domain.
`ifdef EXC_CTRL_TIMER_INT_EN
    assign w_ip7    = r_sync2[5] | int_timer_req;
    assign w_unused = ^{status[31:16], status[7:3]};
`else
    assign w_ip7    = r_sync2[5];
    assign w_unused = ^{status[31:16], status[7:3], int_timer_req};
`endif

    assign cause_ip = {w_ip7, r_sync2[4:0], 2'b00};

    assign w_mem_req = mem_valid && (mem_exc != 3'b000);
    assign w_id_req  = id_valid && (id_ri || id_sys || id_eret);
    assign w_int_req = id_valid && ((cause_ip & status[15:8]) != 8'h00)
                       && status[0] && !status[1] && !status[2];
    assign w_mem_epc = mem_bd ? (mem_pc - 32'd4) : mem_pc;
    assign w_id_epc  = id_bd  ? (id_pc  - 32'd4) : id_pc;

    always_comb begin
        w_req  = 1'b0;
        w_code = C_EC_NONE;
        w_epc  = 32'd0;
        w_bad  = 32'd0;
        if (w_mem_req) begin
            w_req = 1'b1;
            w_epc = w_mem_epc;
            w_bad = mem_addr;
            if (mem_exc[0])
                w_code = C_EC_ADEL;
            else if (mem_exc[1])
                w_code = C_EC_ADES;
            else
                w_code = mem_we ? C_EC_TLBS : C_EC_TLBL;
        end else if (w_id_req) begin
            w_req  = 1'b1;
            w_epc  = w_id_epc;
            w_code = id_ri ? C_EC_RI : (id_sys ? C_EC_SYS : C_EC_ERET);
        end else if (if_adel) begin
            w_req  = 1'b1;
            w_code = C_EC_ADEL;
            w_epc  = if_pc;
            w_bad  = if_pc;
        end else if (w_int_req) begin
            w_req  = 1'b1;
            w_code = C_EC_INT;
            w_epc  = w_id_epc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 6'd0;
            r_sync2 <= 6'd0;
        end else begin
            r_sync1 <= hw_int;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= C_EC_NONE;
            r_epc   <= 32'd0;
            r_bad   <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state <= S_ISSUE;
                        r_code  <= w_code;
                        r_epc   <= w_epc;
                        r_bad   <= w_bad;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_code  <= C_EC_NONE;
                end
                S_WAIT: begin
                    if (exc_jmp_flag) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_code  <= C_EC_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign exc_code     = r_code;
    assign exc_epc      = r_epc;
    assign exc_badvaddr = r_bad;
    assign flush        = r_busy;
    assign stall        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_ctrl
// Purpose  : Scoreboard bench for exc_ctrl; directed vectors push expected
//            issues, a negedge monitor pops and compares each issued request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    localparam logic [4:0] C_EC_NONE = 5'd31;
    localparam logic [4:0] C_EC_ERET = 5'd30;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bad;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] status = '0;
    logic [5:0]  hw_int = '0;
    logic        int_timer_req = 1'b0;
    logic [7:0]  cause_ip;
    logic        if_adel = 1'b0;
    logic [31:0] if_pc = '0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic        id_bd = 1'b0;
    logic        id_sys = 1'b0;
    logic        id_ri = 1'b0;
    logic        id_eret = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = '0;
    logic        mem_bd = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [2:0]  mem_exc = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic [31:0] exc_badvaddr;
    logic        exc_jmp_flag = 1'b0;
    logic        flush;
    logic        stall;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .status(status), .hw_int(hw_int),
        .int_timer_req(int_timer_req), .cause_ip(cause_ip),
        .if_adel(if_adel), .if_pc(if_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_bd(id_bd), .id_sys(id_sys),
        .id_ri(id_ri), .id_eret(id_eret),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
        .mem_addr(mem_addr), .mem_exc(mem_exc), .mem_we(mem_we),
        .exc_code(exc_code), .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr),
        .exc_jmp_flag(exc_jmp_flag), .flush(flush), .stall(stall)
    );

    always #5 clk = ~clk;

    // Monitor: every non-NONE code on the output must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && exc_code !== C_EC_NONE) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got code=%0d epc=%h bad=%h, required no issue",
                         exc_code, exc_epc, exc_badvaddr);
            end else begin
                e = sb.pop_front();
                if (exc_code !== e.code || exc_epc !== e.epc || exc_badvaddr !== e.bad) begin
                    n_err++;
                    $display("FAIL issue: got code=%0d epc=%h bad=%h, required code=%0d epc=%h bad=%h",
                             exc_code, exc_epc, exc_badvaddr, e.code, e.epc, e.bad);
                end
                n_cmp++;
                if (flush !== 1'b1 || stall !== 1'b1) begin
                    n_err++;
                    $display("FAIL issue_flush: got flush=%b stall=%b, required 1/1", flush, stall);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        status = '0; hw_int = '0; int_timer_req = 1'b0;
        if_adel = 1'b0; if_pc = '0;
        id_valid = 1'b0; id_pc = '0; id_bd = 1'b0;
        id_sys = 1'b0; id_ri = 1'b0; id_eret = 1'b0;
        mem_valid = 1'b0; mem_pc = '0; mem_bd = 1'b0;
        mem_addr = '0; mem_exc = '0; mem_we = 1'b0;
    endtask

    // Called with the DUT in ISSUE; drives it through WAIT back to IDLE.
    task automatic finish_txn(input int n_wait);
        clear_reqs();
        tick();
        chk("wait_code", {27'd0, exc_code}, {27'd0, C_EC_NONE});
        chk("wait_flush", {31'd0, flush}, 32'd1);
        repeat (n_wait) begin
            tick();
            chk("wait_stall", {31'd0, stall}, 32'd1);
        end
        exc_jmp_flag = 1'b1;
        tick();
        exc_jmp_flag = 1'b0;
        chk("ack_flush", {31'd0, flush}, 32'd0);
        chk("ack_stall", {31'd0, stall}, 32'd0);
    endtask

    // Inputs must already be driven; expect exactly one issue on the next edge.
    task automatic run(input logic [4:0] code, input logic [31:0] epc,
                       input logic [31:0] bad, input int n_wait);
        exp_t x;
        x.code = code; x.epc = epc; x.bad = bad;
        sb.push_back(x);
        tick();
        finish_txn(n_wait);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(); tick();
        chk("rst_code", {27'd0, exc_code}, {27'd0, C_EC_NONE});
        chk("rst_epc", exc_epc, 32'd0);
        chk("rst_bad", exc_badvaddr, 32'd0);
        chk("rst_cause", {24'd0, cause_ip}, 32'd0);
        chk("rst_flush", {30'd0, flush, stall}, 32'd0);
        rst = 1'b0;
        exc_jmp_flag = 1'b1;
        tick();
        exc_jmp_flag = 1'b0;
        tick();
        chk("idle_jmp_ignored", {31'd0, flush}, 32'd0);

        // Syscall from ID
        id_valid = 1'b1; id_sys = 1'b1; id_pc = 32'h8000_1000; id_bd = 1'b0;
        run(5'd8, 32'h8000_1000, 32'd0, 3);

        // TLB store miss in MEM, delay slot, beats a simultaneous syscall
        mem_valid = 1'b1; mem_exc = 3'd4; mem_we = 1'b1; mem_addr = 32'h0040_0010;
        mem_pc = 32'h8000_0204; mem_bd = 1'b1;
        id_valid = 1'b1; id_sys = 1'b1; id_pc = 32'h8000_0208;
        run(5'd3, 32'h8000_0200, 32'h0040_0010, 2);

        // MEM AdEL
        mem_valid = 1'b1; mem_exc = 3'd1; mem_addr = 32'h0000_0001; mem_pc = 32'h8000_0010;
        run(5'd4, 32'h8000_0010, 32'h0000_0001, 2);

        // MEM AdES beats IF AdEL
        mem_valid = 1'b1; mem_exc = 3'd2; mem_addr = 32'h1000_0002; mem_pc = 32'h8000_0100;
        if_adel = 1'b1; if_pc = 32'h8000_0104;
        run(5'd5, 32'h8000_0100, 32'h1000_0002, 2);

        // MEM TLB load miss in delay slot
        mem_valid = 1'b1; mem_exc = 3'd4; mem_we = 1'b0; mem_addr = 32'h7FFF_F000;
        mem_pc = 32'h8000_0008; mem_bd = 1'b1;
        run(5'd2, 32'h8000_0004, 32'h7FFF_F000, 2);

        // RI over syscall, delay-slot EPC wraps below zero
        id_valid = 1'b1; id_ri = 1'b1; id_sys = 1'b1; id_pc = 32'h0000_0000; id_bd = 1'b1;
        run(5'd10, 32'hFFFF_FFFC, 32'd0, 2);

        // IF AdEL; invalid ID and MEM requests ignored
        id_valid = 1'b0; id_sys = 1'b1; mem_valid = 1'b0; mem_exc = 3'd2;
        if_adel = 1'b1; if_pc = 32'hBFC0_0003;
        run(5'd4, 32'hBFC0_0003, 32'hBFC0_0003, 2);

        // Invalid MEM request alone: nothing issues
        mem_valid = 1'b0; mem_exc = 3'd1; mem_addr = 32'h0000_0003;
        repeat (3) tick();
        chk("mem_invalid_no_issue", {31'd0, flush}, 32'd0);
        clear_reqs();

        // Hardware interrupt through the synchronizer
        status = 32'h0000_0401; hw_int = 6'b000001; id_valid = 1'b1; id_pc = 32'h8000_2000;
        tick();
        chk("cause_lat1", {24'd0, cause_ip}, 32'h00);
        tick();
        chk("cause_lat2", {24'd0, cause_ip}, 32'h04);
        run(5'd0, 32'h8000_2000, 32'd0, 3);

        // EXL set: interrupt pending but not taken
        status = 32'h0000_0403; hw_int = 6'b000001; id_valid = 1'b1; id_pc = 32'h8000_2100;
        repeat (4) tick();
        chk("exl_cause", {24'd0, cause_ip}, 32'h04);
        chk("exl_no_issue", {31'd0, flush}, 32'd0);
        clear_reqs();
        repeat (3) tick();

        // Timer request on IP7
        status = 32'h0000_8001; int_timer_req = 1'b1; id_valid = 1'b1;
        id_pc = 32'h8000_3004; id_bd = 1'b1;
        #1;
`ifdef EXC_CTRL_TIMER_INT_EN
        chk("timer_cause", {24'd0, cause_ip}, 32'h80);
        run(5'd0, 32'h8000_3000, 32'd0, 2);
`else
        chk("timer_cause", {24'd0, cause_ip}, 32'h00);
        repeat (3) tick();
        chk("timer_no_issue", {31'd0, flush}, 32'd0);
        clear_reqs();
`endif

        // Long WAIT with new requests ignored, then reset aborts
        id_valid = 1'b1; id_sys = 1'b1; id_pc = 32'h8000_4000;
        begin
            exp_t x;
            x.code = 5'd8; x.epc = 32'h8000_4000; x.bad = 32'd0;
            sb.push_back(x);
        end
        tick();
        clear_reqs();
        mem_valid = 1'b1; mem_exc = 3'd1; if_adel = 1'b1;
        id_valid = 1'b1; id_eret = 1'b1;
        repeat (10) begin
            tick();
            chk("hold_stall", {30'd0, stall, flush}, 32'd3);
        end
        rst = 1'b1;
        tick();
        chk("abort_flush", {30'd0, flush, stall}, 32'd0);
        chk("abort_code", {27'd0, exc_code}, {27'd0, C_EC_NONE});
        chk("abort_epc", exc_epc, 32'd0);
        clear_reqs();
        rst = 1'b0;
        tick(); tick();
        chk("after_abort_idle", {31'd0, flush}, 32'd0);

        // ERET
        id_valid = 1'b1; id_eret = 1'b1; id_pc = 32'h8000_0300;
        run(C_EC_ERET, 32'h8000_0300, 32'd0, 2);

        tick(); tick();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
